// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared register-file constants and write-back types.
//            REG_BITS/REG_WIDTH  register index width and data width
//            wb_entry_t          queued write-back result {dest, data}
//            wb_src_t            write-back source, used as the arbiter pointer
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int REG_BITS  = 5;
  localparam int REG_WIDTH = 32;

  typedef struct packed {
    logic [REG_BITS-1:0]  dest;
    logic [REG_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_MEM = 1'b0,
    WB_SRC_ALU = 1'b1
  } wb_src_t;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_if
// Purpose  : Bundles the producer handshakes (ALU, load unit), the register
//            file write port and the busy bitmap of regfile_writeback.
//            master : producers / register file / decode side
//            slave  : regfile_writeback side
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_writeback_if #(
  parameter int REG_BITS  = cpu_pkg::REG_BITS,
  parameter int REG_WIDTH = cpu_pkg::REG_WIDTH
);
  logic                   alu_valid;
  logic                   alu_ready;
  logic [REG_BITS-1:0]    alu_dest;
  logic [REG_WIDTH-1:0]   alu_data;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [REG_BITS-1:0]    mem_dest;
  logic [REG_WIDTH-1:0]   mem_data;
  logic                   write;
  logic [REG_BITS-1:0]    wdest;
  logic [REG_WIDTH-1:0]   wdata;
  logic [2**REG_BITS-1:0] busy;

  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    input  alu_ready, mem_ready, write, wdest, wdata, busy
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
    output alu_ready, mem_ready, write, wdest, wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : DEPTH-entry result FIFO for one write-back source.
//            clk, rst            clock, synchronous active-high reset
//            push, din           enqueue (caller guarantees !full)
//            pop                 dequeue head (caller guarantees !empty)
//            full, empty, head   status and head entry
//            ent_valid/ent_dest  per-slot occupancy and destination
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire                              clk,
  input  wire                              rst,
  input  wire                              push,
  input  wb_entry_t                        din,
  input  wire                              pop,
  output logic                             full,
  output logic                             empty,
  output wb_entry_t                        head,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][REG_BITS-1:0]   ent_dest
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rptr];

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= din;
  end

  // Pointers are PW bits wide, so DEPTH being a power of two makes the
  // natural binary rollover the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + PW'(1);
      if (pop)  r_rptr <= r_rptr + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is occupied when its distance from the read pointer is below
  // the current count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] w_off;
    assign w_off        = PW'(i) - r_rptr;
    assign ent_valid[i] = ({1'b0, w_off} < r_count);
    assign ent_dest[i]  = r_mem[i].dest;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Write-side front end of the 32x32 register file. Buffers ALU
//            and load results in per-source FIFOs, serializes them onto the
//            single register file write port with round-robin arbitration,
//            and exports a per-register busy bitmap for decode.
//            clk, rst   clock, synchronous active-high reset
//            bus        regfile_writeback_if.slave: alu_*/mem_* handshakes,
//                       write/wdest/wdata, busy
// Options  : WB_ZERO_DROP_EN - results for register 0 are consumed without
//            a write pulse, and busy[0] is held at 0.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
  parameter int REG_BITS  = cpu_pkg::REG_BITS,
  parameter int REG_WIDTH = cpu_pkg::REG_WIDTH,
  parameter int DEPTH     = 2
) (
  input  wire                  clk,
  input  wire                  rst,
  regfile_writeback_if.slave   bus
);
  import cpu_pkg::*;

  localparam int NREGS = 2**REG_BITS;

  wb_entry_t                        w_mem_in, w_alu_in;
  wb_entry_t                        w_mem_head, w_alu_head, w_pop_entry;
  logic                             w_mem_full, w_mem_empty, w_alu_full, w_alu_empty;
  logic                             w_mem_push, w_alu_push;
  logic                             w_grant_mem, w_grant_alu, w_pop, w_commit;
  logic [DEPTH-1:0]                 w_mem_ev, w_alu_ev;
  logic [DEPTH-1:0][REG_BITS-1:0]   w_mem_ed, w_alu_ed;
  logic [NREGS-1:0]                 w_busy;

  wb_src_t                          r_prio;
  logic                             r_write;
  logic [REG_BITS-1:0]              r_wdest;
  logic [REG_WIDTH-1:0]             r_wdata;

  // Readiness depends only on registered occupancy: a full FIFO refuses
  // even when it pops in the same cycle.
  assign bus.mem_ready = !w_mem_full;
  assign bus.alu_ready = !w_alu_full;
  assign w_mem_push    = bus.mem_valid & !w_mem_full;
  assign w_alu_push    = bus.alu_valid & !w_alu_full;
  assign w_mem_in      = '{dest: bus.mem_dest, data: bus.mem_data};
  assign w_alu_in      = '{dest: bus.alu_dest, data: bus.alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_mem_push),
    .din       (w_mem_in),
    .pop       (w_grant_mem),
    .full      (w_mem_full),
    .empty     (w_mem_empty),
    .head      (w_mem_head),
    .ent_valid (w_mem_ev),
    .ent_dest  (w_mem_ed)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_alu_push),
    .din       (w_alu_in),
    .pop       (w_grant_alu),
    .full      (w_alu_full),
    .empty     (w_alu_empty),
    .head      (w_alu_head),
    .ent_valid (w_alu_ev),
    .ent_dest  (w_alu_ed)
  );

  // r_prio names the source favoured on contention; a lone non-empty
  // source always wins.
  assign w_grant_mem = !w_mem_empty && (w_alu_empty || r_prio == WB_SRC_MEM);
  assign w_grant_alu = !w_alu_empty && !w_grant_mem;
  assign w_pop       = w_grant_mem | w_grant_alu;
  assign w_pop_entry = w_grant_mem ? w_mem_head : w_alu_head;

`ifdef WB_ZERO_DROP_EN
  assign w_commit = w_pop && (w_pop_entry.dest != '0);
`else
  assign w_commit = w_pop;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio  <= WB_SRC_MEM;
      r_write <= 1'b0;
      r_wdest <= '0;
      r_wdata <= '0;
    end else begin
      r_write <= 1'b0;
      if (w_grant_mem) r_prio <= WB_SRC_ALU;
      if (w_grant_alu) r_prio <= WB_SRC_MEM;
      if (w_commit) begin
        r_write <= 1'b1;
        r_wdest <= w_pop_entry.dest;
        r_wdata <= w_pop_entry.data;
      end
    end
  end

  assign bus.write = r_write;
  assign bus.wdest = r_wdest;
  assign bus.wdata = r_wdata;

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_mem_ev[i]) w_busy[w_mem_ed[i]] = 1'b1;
      if (w_alu_ev[i]) w_busy[w_alu_ed[i]] = 1'b1;
    end
    if (r_write) w_busy[r_wdest] = 1'b1;
`ifdef WB_ZERO_DROP_EN
    w_busy[0] = 1'b0;
`endif
  end

  assign bus.busy = w_busy;

endmodule
`default_nettype wire
